multiplier_scheduler: RTL
=========================

MULTIPLIER_SCHEDULER -- requirements
Module: multiplier_scheduler

Interface
REQ-001 SHALL have parameter L_word, default 4, operand width.
REQ-002 SHALL have parameter N_req, default 4, number of requesters.
REQ-003 SHALL have parameter TIMEOUT, default 32, the S_wait cycle limit used when the watchdog is compiled in.
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-low.
REQ-006 req  input  N_req  per-requester request level.
REQ-007 word1_in  input  N_req*L_word  packed multiplicands; slice i belongs to requester i.
REQ-008 word2_in  input  N_req*L_word  packed multipliers; slice i belongs to requester i.
REQ-009 grant  output  N_req  one-hot owner of the multiplier, held for the whole transaction.
REQ-010 ack  output  N_req  one-cycle completion pulse to the owner.
REQ-011 product_out  output  2*L_word  result, valid only while ack is nonzero.
REQ-012 err  output  1  timeout flag, pulses with ack.
REQ-013 busy  output  1  high in every state except S_idle.
REQ-014 mul_start  output  1  Start pulse to the shared shift-add multiplier.
REQ-015 mul_word1, mul_word2  output  L_word each  registered operands to the multiplier.
REQ-016 mul_ready  input  1  multiplier Ready.
REQ-017 mul_product  input  2*L_word  multiplier product.

Function
REQ-018 SHALL implement the FSM states S_idle, S_issue, S_wait and S_done.
REQ-019 S_idle SHALL go to S_issue when any req bit is set and mul_ready=1, else stay in S_idle.
- On that edge: register the one-hot grant.
- Latch the granted requester's word1/word2 slices into mul_word1/mul_word2.
REQ-020 Round-robin:
- Search starts at last_grant+1 and wraps modulo N_req.
- last_grant updates on every grant.
REQ-021 S_issue SHALL drive mul_start=1 for exactly one cycle, then go to S_wait.
REQ-022 S_wait SHALL sample mul_ready from the first cycle after S_issue onward.
- mul_ready=1 -> capture mul_product into product_out, go to S_done.
- This covers zero-operand jobs, where the multiplier goes straight to done with Ready high.
REQ-023 S_done SHALL pulse ack for the granted index for one cycle, drop grant, and return to S_idle.
- Minimum spacing between starts: 4 cycles.
REQ-024 A req dropped mid-transaction SHALL NOT abort the transaction; ack still pulses.
REQ-025 A req held high after its ack SHALL rejoin arbitration.
- Every other pending requester is granted before it is granted again.
REQ-026 Operand changes after the grant SHALL NOT affect the running transaction.
REQ-027 mul_start SHALL never assert while mul_ready=0.
REQ-028 ack and grant SHALL always be one-hot or zero.

Reset
REQ-029 On reset=0 at a clock edge, from any state including mid-transaction:
- state <= S_idle.
- grant, ack, product_out, err, mul_start, mul_word1, mul_word2 <= 0.
- last_grant <= N_req-1, so requester 0 wins first.
REQ-030 A transaction interrupted by reset SHALL produce no ack.

Configuration
REQ-031 With MUL_SCHED_TIMEOUT_EN defined:
- A counter SHALL count the cycles spent in S_wait.
- On reaching TIMEOUT with mul_ready still 0, go to S_done with err=1 and product_out=0.
REQ-032 Without MUL_SCHED_TIMEOUT_EN:
- err SHALL be tied to 0.
- S_wait SHALL wait indefinitely.
- No counter logic is present.

Structure
REQ-033 Package mul_sched_pkg SHALL hold the state encoding and the default constants for L_word, N_req and TIMEOUT.
REQ-034 Sub-module rr_arbiter SHALL be a combinational round-robin pick from req and last_grant, one-hot output.
- Instantiated once.

Verification
REQ-035 req=0001, word1=3, word2=5, multiplier model -> mul_start 1 cycle after the grant edge; ack=0001 with product_out=15.
REQ-036 req=1111 held continuously with distinct operands -> acks in order 0001, 0010, 0100, 1000, 0001; each product is correct.
REQ-037 req=0100, word1=0, word2=7 (multiplier Ready stays high) -> ack=0100 with product_out=0; no hang.
REQ-038 reset=0 for one edge during S_wait of requester 2 -> no ack; busy=0; the next grant goes to requester 0 when all request.
REQ-039 With MUL_SCHED_TIMEOUT_EN and mul_ready forced 0 after start -> after 32 S_wait cycles, ack plus err=1 and product_out=0.
REQ-040 req bit deasserted during S_wait -> ack still pulses; mul_word1/mul_word2 are unchanged by operand edits.

Source files
------------

// File: rtl/mul_sched_pkg.sv
// Shared definitions for the multiplier scheduler: FSM encoding, default
// sizing constants and the round-robin index wrap helper.
package mul_sched_pkg;

    localparam int L_WORD_DEF  = 4;
    localparam int N_REQ_DEF   = 4;
    localparam int TIMEOUT_DEF = 32;

    typedef enum logic [1:0] {
        S_idle  = 2'd0,
        S_issue = 2'd1,
        S_wait  = 2'd2,
        S_done  = 2'd3
    } state_t;

    function automatic int rr_wrap(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the search begins one past the previous
// winner and wraps, so the previous winner has the lowest priority.
module rr_arbiter
    import mul_sched_pkg::*;
#(
    parameter int N_req = N_REQ_DEF,
    parameter int IDX_W = 2
) (
    input  logic [N_req-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N_req-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        valid   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N_req; k++) begin
            cand = IDX_W'(rr_wrap(int'(last_grant), k, N_req));
            if (!valid && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multiplier_scheduler.sv
// Shares one shift-add multiplier among N_req requesters with round-robin grant.
// Define MUL_SCHED_TIMEOUT_EN to add the S_wait watchdog (err flag, zero product).
//
// state   | meaning
// S_idle  | no owner; arbitrate when a request is pending and the multiplier is ready
// S_issue | owner registered, operands latched, mul_start high this cycle
// S_wait  | waiting for multiplier Ready (or watchdog expiry)
// S_done  | ack pulse to the owner with product_out (and err) valid
module multiplier_scheduler
    import mul_sched_pkg::*;
#(
    parameter int L_word  = L_WORD_DEF,
    parameter int N_req   = N_REQ_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_req-1:0]      req,
    input  logic [N_req*L_word-1:0] word1_in,
    input  logic [N_req*L_word-1:0] word2_in,
    output logic [N_req-1:0]      grant,
    output logic [N_req-1:0]      ack,
    output logic [2*L_word-1:0]   product_out,
    output logic                  err,
    output logic                  busy,
    output logic                  mul_start,
    output logic [L_word-1:0]     mul_word1,
    output logic [L_word-1:0]     mul_word2,
    input  logic                  mul_ready,
    input  logic [2*L_word-1:0]   mul_product
);

    localparam int IDX_W = (N_req > 1) ? $clog2(N_req) : 1;

    if (N_req < 2) begin : g_bad_nreq
        $error("multiplier_scheduler: N_req must be at least 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("multiplier_scheduler: TIMEOUT must be at least 1");
    end

    state_t              state_q, state_d;
    logic [N_req-1:0]    grant_d, ack_d;
    logic [2*L_word-1:0] product_d;
    logic                start_d;
    logic [L_word-1:0]   word1_d, word2_d;
    logic [IDX_W-1:0]    last_grant_q, last_grant_d;

    logic [N_req-1:0]    arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_valid;

    rr_arbiter #(
        .N_req (N_req),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req        (req),
        .last_grant (last_grant_q),
        .gnt        (arb_gnt),
        .gnt_idx    (arb_idx),
        .valid      (arb_valid)
    );

`ifdef MUL_SCHED_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             err_d;
`endif

    assign busy = (state_q != S_idle);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant;
        ack_d        = '0;
        product_d    = '0;
        start_d      = 1'b0;
        word1_d      = mul_word1;
        word2_d      = mul_word2;
        last_grant_d = last_grant_q;
`ifdef MUL_SCHED_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q;
        err_d        = 1'b0;
`endif
        case (state_q)
            S_idle: begin
                if (arb_valid && mul_ready) begin
                    state_d      = S_issue;
                    grant_d      = arb_gnt;
                    last_grant_d = arb_idx;
                    word1_d      = word1_in[int'(arb_idx)*L_word +: L_word];
                    word2_d      = word2_in[int'(arb_idx)*L_word +: L_word];
                    start_d      = 1'b1;
                end
            end
            S_issue: begin
                state_d = S_wait;
`ifdef MUL_SCHED_TIMEOUT_EN
                // Terminal count 0 is reached on the TIMEOUT-th S_wait cycle.
                wait_cnt_d = CNT_W'(TIMEOUT - 1);
`endif
            end
            S_wait: begin
                if (mul_ready) begin
                    state_d   = S_done;
                    ack_d     = grant;
                    grant_d   = '0;
                    product_d = mul_product;
                end
`ifdef MUL_SCHED_TIMEOUT_EN
                else if (wait_cnt_q == '0) begin
                    state_d = S_done;
                    ack_d   = grant;
                    grant_d = '0;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
`endif
            end
            S_done: begin
                state_d = S_idle;
            end
            default: begin
                state_d = S_idle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_idle;
            grant        <= '0;
            ack          <= '0;
            product_out  <= '0;
            mul_start    <= 1'b0;
            mul_word1    <= '0;
            mul_word2    <= '0;
            last_grant_q <= IDX_W'(N_req - 1);
        end else begin
            state_q      <= state_d;
            grant        <= grant_d;
            ack          <= ack_d;
            product_out  <= product_d;
            mul_start    <= start_d;
            mul_word1    <= word1_d;
            mul_word2    <= word2_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifdef MUL_SCHED_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            err        <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            err        <= err_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
